// File: rtl/tcl_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tcl_vc_arbiter
// Description : Drains four virtual-channel FIFOs into one destination FIFO
//               with round-robin grants, a hysteresis watermark pause,
//               an init/config sequence and per-VC transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tcl_vc_arbiter #(
  parameter int DATA_W = 12,
  parameter int NUM_VC = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_init,
  input  logic [2:0]        i_umbral_alto,
  input  logic [2:0]        i_umbral_bajo,
  input  logic [NUM_VC-1:0] i_fifo_empty,
  input  logic [DATA_W-1:0] i_data_vc0,
  input  logic [DATA_W-1:0] i_data_vc1,
  input  logic [DATA_W-1:0] i_data_vc2,
  input  logic [DATA_W-1:0] i_data_vc3,
  input  logic [3:0]        i_dest_count,
  input  logic              i_req,
  input  logic [2:0]        i_idx,
  output logic [NUM_VC-1:0] o_pop_vc,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_push_out,
  output logic              o_paused,
  output logic [1:0]        o_state,
  output logic [CNT_W-1:0]  o_counter_out,
  output logic              o_counter_valid
);

  // Pointer width for the four-channel round robin.
  localparam int c_PTR_W = 2;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [c_PTR_W-1:0]   r_ptr;
  logic [2:0]           r_alto;
  logic [2:0]           r_bajo;
  logic                 r_paused;

  // Grant search results
  logic                 w_pop_en;
  logic                 w_grant_vld;
  logic [c_PTR_W-1:0]   w_grant_idx;
  logic [c_PTR_W-1:0]   w_cand;

  // Pipeline: stage 1 remembers the grant, stage 2 presents the push
  logic                 r_gnt_vld;
  logic [c_PTR_W-1:0]   r_gnt_idx;
  logic                 r_push_out;
  logic [c_PTR_W-1:0]   r_push_idx;
  logic [DATA_W-1:0]    r_data_out;
  logic [DATA_W-1:0]    w_data_sel;

  // Watermark comparisons on the destination occupancy
  logic                 w_pause_set;
  logic                 w_pause_clr;

  // Counters, flattened so the generate loop can own each slice
  logic [NUM_VC*CNT_W-1:0] w_cnt_flat;
  logic [CNT_W-1:0]        w_cnt_sel;
  logic [CNT_W-1:0]        r_counter_out;
  logic                    r_counter_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ACTIVE only falls back to IDLE once nothing is in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        if (!i_init) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (i_init) begin
          w_state_nxt = ST_INIT;
        end else if (~&i_fifo_empty) begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (i_init) begin
          w_state_nxt = ST_INIT;
        end else if ((&i_fifo_empty) && !r_gnt_vld) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

  assign w_pop_en = (r_state == ST_ACTIVE) && !r_paused && !i_init;

  // Round-robin search: first non-empty channel starting at the pointer.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = r_ptr;
    w_cand      = r_ptr;
    for (int k = 0; k < NUM_VC; k++) begin
      w_cand = r_ptr + 2'(k);
      if (w_pop_en && !w_grant_vld && !i_fifo_empty[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // One-hot pop of the granted channel.
  always_comb begin
    o_pop_vc = '0;
    if (w_grant_vld) begin
      o_pop_vc[w_grant_idx] = 1'b1;
    end
  end

  // Pointer moves past the winner; it holds when nobody is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant_vld) begin
      r_ptr <= w_grant_idx + 2'd1;
    end
  end

  // Thresholds follow the inputs for the whole configuration phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alto <= '0;
      r_bajo <= '0;
    end else if (r_state == ST_INIT) begin
      r_alto <= i_umbral_alto;
      r_bajo <= i_umbral_bajo;
    end
  end

  assign w_pause_set = (i_dest_count >= {1'b0, r_alto});
  assign w_pause_clr = (i_dest_count <= {1'b0, r_bajo});

  // Hysteresis pause; only live once configuration is done, set has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paused <= 1'b0;
    end else if ((r_state == ST_INIT) || (r_state == ST_RESET)) begin
      r_paused <= 1'b0;
    end else if (w_pause_set) begin
      r_paused <= 1'b1;
    end else if (w_pause_clr) begin
      r_paused <= 1'b0;
    end
  end

  // Stage 1: remember which channel was popped; its data arrives next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_vld <= 1'b0;
      r_gnt_idx <= '0;
    end else begin
      r_gnt_vld <= w_grant_vld;
      r_gnt_idx <= w_grant_idx;
    end
  end

  // Select the read data of the channel popped last cycle.
  always_comb begin
    w_data_sel = i_data_vc0;
    case (r_gnt_idx)
      2'd1:    w_data_sel = i_data_vc1;
      2'd2:    w_data_sel = i_data_vc2;
      2'd3:    w_data_sel = i_data_vc3;
      default: w_data_sel = i_data_vc0;
    endcase
  end

  // Stage 2: present the word; dataOut holds between pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_push_out <= 1'b0;
      r_push_idx <= '0;
      r_data_out <= '0;
    end else begin
      r_push_out <= r_gnt_vld;
      if (r_gnt_vld) begin
        r_data_out <= w_data_sel;
        r_push_idx <= r_gnt_idx;
      end
    end
  end

  // Per-channel transfer counters, wrapping naturally at 2**CNT_W.
  for (genvar g = 0; g < NUM_VC; g++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    // Count completed pushes of this channel; cleared while configuring.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (r_state == ST_INIT) begin
        r_cnt <= '0;
      end else if (r_push_out && (r_push_idx == 2'(g))) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_cnt_flat[g*CNT_W +: CNT_W] = r_cnt;
  end

  assign w_cnt_sel = (i_idx < 3'(NUM_VC)) ? w_cnt_flat[i_idx[1:0]*CNT_W +: CNT_W] : '0;

  // Counter read-back, one cycle after the request; zero when not requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_counter_out   <= '0;
      r_counter_valid <= 1'b0;
    end else begin
      r_counter_valid <= i_req;
      r_counter_out   <= i_req ? w_cnt_sel : '0;
    end
  end

  assign o_data_out      = r_data_out;
  assign o_push_out      = r_push_out;
  assign o_paused        = r_paused;
  assign o_state         = r_state;
  assign o_counter_out   = r_counter_out;
  assign o_counter_valid = r_counter_valid;

endmodule
`default_nettype wire

// File: tb/tb_tcl_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcl_vc_arbiter
// Description : Scoreboard bench for tcl_vc_arbiter with a small model of the
//               four upstream VC FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcl_vc_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic [2:0]  alto = 3'd0;
  logic [2:0]  bajo = 3'd0;
  logic [3:0]  fe = 4'hF;
  logic [11:0] dv0 = '0, dv1 = '0, dv2 = '0, dv3 = '0;
  logic [3:0]  dcnt = 4'd0;
  logic        req = 1'b0;
  logic [2:0]  idx = 3'd0;

  logic [3:0]  pop;
  logic [11:0] dout;
  logic        push;
  logic        paused;
  logic [1:0]  st;
  logic [4:0]  cout;
  logic        cvld;

  int total = 0;
  int bad   = 0;
  int n_pops = 0;

  logic [11:0] q0[$], q1[$], q2[$], q3[$];
  logic [11:0] exp_push[$];
  logic [3:0]  exp_pop[$];
  logic [4:0]  exp_cnt[$];

  always #5 clk = ~clk;

  tcl_vc_arbiter #(.DATA_W(12), .NUM_VC(4), .CNT_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_init         (init),
    .i_umbral_alto  (alto),
    .i_umbral_bajo  (bajo),
    .i_fifo_empty   (fe),
    .i_data_vc0     (dv0),
    .i_data_vc1     (dv1),
    .i_data_vc2     (dv2),
    .i_data_vc3     (dv3),
    .i_dest_count   (dcnt),
    .i_req          (req),
    .i_idx          (idx),
    .o_pop_vc       (pop),
    .o_data_out     (dout),
    .o_push_out     (push),
    .o_paused       (paused),
    .o_state        (st),
    .o_counter_out  (cout),
    .o_counter_valid(cvld)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic upd_fe();
    fe = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
  endtask

  // Put one word in a VC FIFO; the caller adds the matching expectations.
  task automatic load(input int vc, input logic [11:0] d);
    case (vc)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
    upd_fe();
  endtask

  task automatic expect_xfer(input int vc, input logic [11:0] d);
    exp_pop.push_back(4'(1 << vc));
    exp_push.push_back(d);
  endtask

  // One clock: sample the pop before the edge, apply it to the FIFO model after.
  task automatic step();
    logic [3:0] p;
    @(negedge clk);
    p = pop;
    @(posedge clk);
    #1;
    if (p != 4'd0) n_pops++;
    if (p[0] && q0.size() > 0) dv0 = q0.pop_front();
    if (p[1] && q1.size() > 0) dv1 = q1.pop_front();
    if (p[2] && q2.size() > 0) dv2 = q2.pop_front();
    if (p[3] && q3.size() > 0) dv3 = q3.pop_front();
    upd_fe();
  endtask

  task automatic drain(input string name, input int max);
    int k;
    k = 0;
    while ((exp_push.size() + exp_pop.size() + exp_cnt.size()) != 0 && k < max) begin
      step();
      k++;
    end
    chk(name, 32'(exp_push.size() + exp_pop.size() + exp_cnt.size()), 32'd0);
    exp_push.delete();
    exp_pop.delete();
    exp_cnt.delete();
  endtask

  // Monitor: compares every pop, push and counter read against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (pop != 4'd0) begin
        chk("pop_on_empty", 32'(pop & fe), 32'd0);
        if (exp_pop.size() == 0) chk("pop_unexpected", 32'(pop), 32'd0);
        else chk("pop_order", 32'(pop), 32'(exp_pop.pop_front()));
      end
      if (push) begin
        if (exp_push.size() == 0) chk("push_unexpected", 32'(push), 32'd0);
        else chk("push_data", 32'(dout), 32'(exp_push.pop_front()));
      end
      if (cvld) begin
        if (exp_cnt.size() == 0) chk("cnt_unexpected", 32'(cvld), 32'd0);
        else chk("counter_out", 32'(cout), 32'(exp_cnt.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops_at_pause;
    // ---- 1: reset and configuration
    step(); step(); step();
    chk("reset_outputs", 32'({pop, dout, push, paused, st, cout, cvld}), 32'd0);
    rst_n = 1'b1; init = 1'b1; alto = 3'd6; bajo = 3'd2;
    chk("state_reset", 32'(st), 32'd0);
    step();
    chk("state_init", 32'(st), 32'd1);
    step();
    chk("state_init_hold", 32'(st), 32'd1);
    chk("init_outputs", 32'({pop, dout, push, paused, cout, cvld}), 32'd0);
    init = 1'b0;
    step();
    chk("state_idle", 32'(st), 32'd2);

    // ---- 2: single VC with three words
    load(2, 12'hA0A); load(2, 12'hB0B); load(2, 12'hC0C);
    expect_xfer(2, 12'hA0A); expect_xfer(2, 12'hB0B); expect_xfer(2, 12'hC0C);
    drain("s2_drain", 30);
    step(); step(); step();
    chk("s2_state_idle", 32'(st), 32'd2);

    // ---- 5a: counter read-back
    req = 1'b1; idx = 3'd2; exp_cnt.push_back(5'd3);
    step();
    idx = 3'd5; exp_cnt.push_back(5'd0);
    step();
    req = 1'b0;
    step();
    chk("cnt_idle_valid", 32'(cvld), 32'd0);
    chk("cnt_idle_out", 32'(cout), 32'd0);
    drain("s5a_drain", 5);

    // Move the pointer back to 0 via a single VC3 transfer
    load(3, 12'h333); expect_xfer(3, 12'h333);
    drain("ptr_drain", 20);
    step(); step();

    // ---- 3: all VCs, two words each
    for (int j = 0; j < 2; j++)
      for (int v = 0; v < 4; v++) load(v, 12'(12'h100 + v * 16 + j));
    for (int j = 0; j < 2; j++)
      for (int v = 0; v < 4; v++) expect_xfer(v, 12'(12'h100 + v * 16 + j));
    drain("s3_drain", 40);
    step(); step();

    // ---- 4: watermark pause with hysteresis
    for (int j = 0; j < 3; j++)
      for (int v = 0; v < 4; v++) load(v, 12'(12'h400 + v * 16 + j));
    for (int j = 0; j < 3; j++)
      for (int v = 0; v < 4; v++) expect_xfer(v, 12'(12'h400 + v * 16 + j));
    n_pops = 0;
    for (int k = 0; k < 20 && n_pops < 3; k++) step();
    dcnt = 4'd6;
    step();
    chk("pause_set", 32'(paused), 32'd1);
    chk("pause_no_pop", 32'(pop), 32'd0);
    pops_at_pause = n_pops;
    step();
    chk("pause_no_pop2", 32'(pop), 32'd0);
    dcnt = 4'd3;
    step(); step();
    chk("pause_hold", 32'(paused), 32'd1);
    chk("pause_hold_pop", 32'(pop), 32'd0);
    chk("pause_pop_count", 32'(n_pops), 32'(pops_at_pause));
    dcnt = 4'd2;
    step();
    chk("pause_clear", 32'(paused), 32'd0);
    dcnt = 4'd0;
    drain("s4_drain", 40);
    step(); step();

    // ---- 5b: re-init clears counters, then 33 transfers on VC0
    init = 1'b1;
    step();
    init = 1'b0;
    step();
    chk("reinit_idle", 32'(st), 32'd2);
    for (int k = 0; k < 33; k++) begin
      load(0, 12'(12'h600 + k));
      expect_xfer(0, 12'(12'h600 + k));
    end
    drain("s5b_drain", 80);
    step(); step();
    req = 1'b1; idx = 3'd0; exp_cnt.push_back(5'd1);
    step();
    idx = 3'd2; exp_cnt.push_back(5'd0);
    step();
    req = 1'b0;
    drain("s5b_cnt_drain", 5);

    // ---- 6: reset in the middle of a transfer
    for (int k = 0; k < 5; k++) load(1, 12'(12'h700 + k));
    exp_pop.push_back(4'b0010); exp_pop.push_back(4'b0010);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({pop, dout, push, paused, st, cout, cvld}), 32'd0);
    q1.delete();
    upd_fe();
    step(); step(); step();
    chk("midreset_hold", 32'({pop, dout, push, paused, st, cout, cvld}), 32'd0);
    rst_n = 1'b1; init = 1'b1;
    step(); step();
    init = 1'b0;
    step();
    chk("s6_state_idle", 32'(st), 32'd2);
    for (int v = 0; v < 4; v++) begin
      req = 1'b1; idx = 3'(v); exp_cnt.push_back(5'd0);
      step();
    end
    req = 1'b0;
    drain("s6_drain", 10);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
